// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   MEM_B/MEM_H/MEM_W/MEM_X : access width encodings (req_width, mem_width)
//   lsu_state_e             : LSU control state
//   is_misaligned()         : alignment test for a width/address pair
package lsu_pkg;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;
    localparam logic [1:0] MEM_X = 2'd3;  // illegal width

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (width)
            MEM_H:   mis = addr_lo[0];
            MEM_W:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data extension (combinational).
//   width       : access width (MEM_B / MEM_H / MEM_W)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   data_in     : right-justified responder data
//   data_out    : 32-bit extended load result (word passes through)
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  width,
    input  logic        is_unsigned,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    logic fill_b;
    logic fill_h;

    assign fill_b = ~is_unsigned & data_in[7];
    assign fill_h = ~is_unsigned & data_in[15];

    always_comb begin
        data_out = data_in;
        case (width)
            MEM_B:   data_out = {{24{fill_b}}, data_in[7:0]};
            MEM_H:   data_out = {{16{fill_h}}, data_in[15:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one pipeline access at a time, runs it on a simple
// strobe/ready memory bus with a BUSY-cycle timeout, and returns a one-cycle
// response with extended load data or an error flag.
//
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses without bus activity; otherwise they are issued unchanged.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write, req_width,       store flag, width, load zero-extend flag,
//   req_unsigned, req_addr,     byte address, right-justified store data
//   req_wdata
//   resp_valid/resp_rdata/      one-cycle completion pulse, load data, error
//   resp_err
//   mem_addr/mem_width/         bus address, width, store data (held registers)
//   mem_write_data
//   mem_read_valid/             bus strobes, high only in BUSY
//   mem_write_valid
//   mem_read_data/mem_ready     responder data and completion
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read_valid,
    output logic        mem_write_valid,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  width_q;
    logic        write_q, unsigned_q, err_q;
    logic [7:0]  cnt_q;

    logic        accept, reject, timeout;
    logic [31:0] ext_data;

    assign accept  = req_valid && (state_q == StIdle);
    assign reject  = (req_width == MEM_X) || (TrapEn && is_misaligned(req_width, req_addr[1:0]));
    // cnt_q holds (BUSY cycle number - 1); a ready in the final cycle still completes.
    assign timeout = (state_q == StBusy) && (cnt_q == LastCnt) && !mem_ready;

    lsu_extend u_extend (
        .width      (width_q),
        .is_unsigned(unsigned_q),
        .data_in    (mem_read_data),
        .data_out   (ext_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = reject ? StResp : StBusy;
            end
            StBusy: begin
                if (mem_ready || timeout) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; strobes come from state and registers only, never from req_*.
    always_comb begin
        req_ready       = (state_q == StIdle);
        mem_read_valid  = (state_q == StBusy) && !write_q;
        mem_write_valid = (state_q == StBusy) && write_q;
        resp_valid      = (state_q == StResp);
        resp_err        = (state_q == StResp) && err_q;
        resp_rdata      = (state_q == StResp) ? rdata_q : 32'd0;
    end

    assign mem_addr       = addr_q;
    assign mem_width      = width_q;
    assign mem_write_data = wdata_q;

    // Request capture, BUSY counter and response data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            width_q    <= MEM_B;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            cnt_q      <= 8'd0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                width_q    <= req_width;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                err_q      <= reject;
                rdata_q    <= 32'd0;
                cnt_q      <= 8'd0;
            end else if (state_q == StBusy) begin
                cnt_q <= cnt_q + 8'd1;
                if (mem_ready) begin
                    err_q   <= 1'b0;
                    rdata_q <= write_q ? 32'd0 : ext_data;
                end else if (timeout) begin
                    err_q   <= 1'b1;
                    rdata_q <= 32'd0;
                end
            end
        end
    end

endmodule
